// File: rtl/data_ram_arbiter.sv
// Two-requester (CPU, debug) arbiter/sequencer for the single-port data RAM.
// Optional macro ARB_DBG_WRITE_EN: when undefined, debug writes are acked but flagged and blocked.
module data_ram_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_ack,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_ram_read,
  output logic              o_ram_write,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_busy,
  output logic              o_owner,
  output logic              o_dbg_wr_err
);

`ifdef ARB_DBG_WRITE_EN
  localparam logic DBG_WR_EN = 1'b1;
`else
  localparam logic DBG_WR_EN = 1'b0;
`endif

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic own_q, own_d;
  logic busy_q, busy_d;
  logic rd_q, rd_d;
  logic wr_q, wr_d;
  logic cack_q, cack_d;
  logic dack_q, dack_d;
  logic err_q, err_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [DATA_W-1:0] rwd_q, rwd_d;
  logic [DATA_W-1:0] crd_q, crd_d;
  logic [DATA_W-1:0] drd_q, drd_d;

  logic dbg_win;
  logic win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // CPU has priority unless debug has waited STARVE_LIMIT CPU grants
  assign dbg_win   = i_dbg_req & (~i_cpu_req | (cnt_q == LIMIT));
  assign win_we    = dbg_win ? i_dbg_we    : i_cpu_we;
  assign win_addr  = dbg_win ? i_dbg_addr  : i_cpu_addr;
  assign win_wdata = dbg_win ? i_dbg_wdata : i_cpu_wdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    own_d   = own_q;
    busy_d  = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    cack_d  = 1'b0;
    dack_d  = 1'b0;
    err_d   = 1'b0;
    raddr_d = '0;
    rwd_d   = '0;
    crd_d   = crd_q;
    drd_d   = drd_q;
    unique case (state_q)
      IDLE: begin
        if (!i_dbg_req) cnt_d = 4'd0;
        if (i_cpu_req || i_dbg_req) begin
          state_d = ISSUE;
          busy_d  = 1'b1;
          we_d    = win_we;
          own_d   = dbg_win;
          rd_d    = ~win_we;
          wr_d    = win_we & (~dbg_win | DBG_WR_EN);
          raddr_d = win_addr;
          rwd_d   = win_wdata;
          if (dbg_win) cnt_d = 4'd0;
          else if (i_dbg_req) cnt_d = cnt_q + 4'd1;
        end
      end
      ISSUE: begin
        state_d = ACK;
        busy_d  = 1'b1;
        cack_d  = ~own_q;
        dack_d  = own_q;
        err_d   = own_q & we_q & ~DBG_WR_EN;
      end
      ACK: begin
        state_d = IDLE;
        if (!we_q) begin
          if (own_q) drd_d = i_ram_rdata;
          else       crd_d = i_ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      own_q   <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cack_q  <= 1'b0;
      dack_q  <= 1'b0;
      err_q   <= 1'b0;
      raddr_q <= '0;
      rwd_q   <= '0;
      crd_q   <= '0;
      drd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      own_q   <= own_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cack_q  <= cack_d;
      dack_q  <= dack_d;
      err_q   <= err_d;
      raddr_q <= raddr_d;
      rwd_q   <= rwd_d;
      crd_q   <= crd_d;
      drd_q   <= drd_d;
    end
  end

  // RAM data lands in the ACK cycle; forward it then, hold the copy afterwards
  assign o_cpu_rdata  = (cack_q & ~we_q) ? i_ram_rdata : crd_q;
  assign o_dbg_rdata  = (dack_q & ~we_q) ? i_ram_rdata : drd_q;
  assign o_cpu_ack    = cack_q;
  assign o_dbg_ack    = dack_q;
  assign o_ram_read   = rd_q;
  assign o_ram_write  = wr_q;
  assign o_ram_addr   = raddr_q;
  assign o_ram_wdata  = rwd_q;
  assign o_busy       = busy_q;
  assign o_owner      = own_q;
  assign o_dbg_wr_err = err_q;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed vector bench for data_ram_arbiter with a synchronous RAM model.
module tb_data_ram_arbiter;

`ifdef ARB_DBG_WRITE_EN
  localparam logic DW = 1'b1;
`else
  localparam logic DW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic creq, cwe, dreq, dwe;
  logic [7:0] caddr, daddr;
  logic [15:0] cwd, dwd;
  logic cack, dack, rrd, rwr, busy, own, err;
  logic [15:0] crd, drd, rwdat, ram_rdata;
  logic [7:0] raddr;

  logic [15:0] mem [256];
  logic ram_init;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_ram_arbiter #(.STARVE_LIMIT(4), .ADDR_W(8), .DATA_W(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(creq), .i_cpu_we(cwe), .i_cpu_addr(caddr), .i_cpu_wdata(cwd),
    .o_cpu_ack(cack), .o_cpu_rdata(crd),
    .i_dbg_req(dreq), .i_dbg_we(dwe), .i_dbg_addr(daddr), .i_dbg_wdata(dwd),
    .o_dbg_ack(dack), .o_dbg_rdata(drd),
    .o_ram_read(rrd), .o_ram_write(rwr), .o_ram_addr(raddr),
    .o_ram_wdata(rwdat), .i_ram_rdata(ram_rdata),
    .o_busy(busy), .o_owner(own), .o_dbg_wr_err(err)
  );

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
      mem[8'h10] <= 16'hBEEF;
      mem[8'h30] <= 16'h5555;
      ram_rdata <= 16'h0;
    end else begin
      if (rwr) mem[raddr] <= rwdat;
      if (rrd) ram_rdata <= mem[raddr];
    end
  end

  typedef struct {
    logic rst;
    logic creq, cwe;
    logic [7:0] caddr;
    logic [15:0] cwd;
    logic dreq, dwe;
    logic [7:0] daddr;
    logic [15:0] dwd;
    logic [62:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic r, cr, cw, input logic [7:0] ca, input logic [15:0] cd,
    input logic dr, dw, input logic [7:0] da, input logic [15:0] dd,
    input logic [6:0] fl, input logic [15:0] ecr, edr,
    input logic [7:0] era, input logic [15:0] erw);
    vec_t v;
    v.rst = r; v.creq = cr; v.cwe = cw; v.caddr = ca; v.cwd = cd;
    v.dreq = dr; v.dwe = dw; v.daddr = da; v.dwd = dd;
    v.exp = {fl, ecr, edr, era, erw};
    tbl.push_back(v);
  endtask

  function automatic logic [62:0] outs();
    return {cack, dack, rrd, rwr, busy, own, err, crd, drd, raddr, rwdat};
  endfunction

  logic [15:0] rd30;
  logic [6:0] fw;
  logic [6:0] fe;
  int acks;
  logic seq_exp [6];

  initial begin
    rd30 = DW ? 16'hAAAA : 16'h5555;
    fw = {1'b0, 1'b0, 1'b0, DW, 1'b1, 1'b1, 1'b0};
    fe = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, ~DW};
    // flags: cack dack rd wr busy own err
    add(1,0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 7'b0000000, 16'h0000,16'h0000,8'h00,16'h0000);
    add(0,1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 7'b0010100, 16'h0000,16'h0000,8'h10,16'h0000);
    add(0,1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 7'b1000100, 16'hBEEF,16'h0000,8'h00,16'h0000);
    add(0,0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 7'b0000000, 16'hBEEF,16'h0000,8'h00,16'h0000);
    add(0,1,1,8'h20,16'h1234, 0,0,8'h00,16'h0000, 7'b0001100, 16'hBEEF,16'h0000,8'h20,16'h1234);
    add(0,1,1,8'h20,16'h1234, 0,0,8'h00,16'h0000, 7'b1000100, 16'hBEEF,16'h0000,8'h00,16'h0000);
    add(0,0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 7'b0000000, 16'hBEEF,16'h0000,8'h00,16'h0000);
    add(0,0,0,8'h00,16'h0000, 1,0,8'h20,16'h0000, 7'b0010110, 16'hBEEF,16'h0000,8'h20,16'h0000);
    add(0,0,0,8'h00,16'h0000, 1,0,8'h20,16'h0000, 7'b0100110, 16'hBEEF,16'h1234,8'h00,16'h0000);
    add(0,0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 7'b0000010, 16'hBEEF,16'h1234,8'h00,16'h0000);
    add(0,1,0,8'h10,16'h0000, 1,0,8'h20,16'h0000, 7'b0010100, 16'hBEEF,16'h1234,8'h10,16'h0000);
    add(0,1,0,8'h10,16'h0000, 1,0,8'h20,16'h0000, 7'b1000100, 16'hBEEF,16'h1234,8'h00,16'h0000);
    add(0,0,0,8'h00,16'h0000, 1,0,8'h20,16'h0000, 7'b0000000, 16'hBEEF,16'h1234,8'h00,16'h0000);
    add(0,0,0,8'h00,16'h0000, 1,0,8'h20,16'h0000, 7'b0010110, 16'hBEEF,16'h1234,8'h20,16'h0000);
    add(0,0,0,8'h00,16'h0000, 1,0,8'h20,16'h0000, 7'b0100110, 16'hBEEF,16'h1234,8'h00,16'h0000);
    add(0,0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 7'b0000010, 16'hBEEF,16'h1234,8'h00,16'h0000);
    add(0,0,0,8'h00,16'h0000, 1,1,8'h30,16'hAAAA, fw,         16'hBEEF,16'h1234,8'h30,16'hAAAA);
    add(0,0,0,8'h00,16'h0000, 1,1,8'h30,16'hAAAA, fe,         16'hBEEF,16'h1234,8'h00,16'h0000);
    add(0,0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 7'b0000010, 16'hBEEF,16'h1234,8'h00,16'h0000);
    add(0,0,0,8'h00,16'h0000, 1,0,8'h30,16'h0000, 7'b0010110, 16'hBEEF,16'h1234,8'h30,16'h0000);
    add(0,0,0,8'h00,16'h0000, 1,0,8'h30,16'h0000, 7'b0100110, 16'hBEEF,rd30,    8'h00,16'h0000);
    add(0,0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 7'b0000010, 16'hBEEF,rd30,    8'h00,16'h0000);
    add(0,1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 7'b0010100, 16'hBEEF,rd30,    8'h10,16'h0000);
    add(1,1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 7'b0000000, 16'h0000,16'h0000,8'h00,16'h0000);
    add(0,1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 7'b0010100, 16'h0000,16'h0000,8'h10,16'h0000);
    add(0,1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 7'b1000100, 16'hBEEF,16'h0000,8'h00,16'h0000);
    add(0,0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 7'b0000000, 16'hBEEF,16'h0000,8'h00,16'h0000);

    ram_init = 1'b1;
    rst = 1'b1;
    creq = 0; cwe = 0; caddr = 0; cwd = 0;
    dreq = 0; dwe = 0; daddr = 0; dwd = 0;
    @(posedge clk); #1;
    ram_init = 1'b0;

    foreach (tbl[k]) begin
      rst = tbl[k].rst;
      creq = tbl[k].creq; cwe = tbl[k].cwe;
      caddr = tbl[k].caddr; cwd = tbl[k].cwd;
      dreq = tbl[k].dreq; dwe = tbl[k].dwe;
      daddr = tbl[k].daddr; dwd = tbl[k].dwd;
      @(posedge clk); #1;
      n_cmp++;
      if (outs() !== tbl[k].exp) begin
        n_bad++;
        $display("FAIL vec%0d got=%h exp=%h", k, outs(), tbl[k].exp);
      end
    end

    // starvation: both hold reads; expect C C C C D C
    seq_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rst = 0;
    creq = 1; cwe = 0; caddr = 8'h10; cwd = 0;
    dreq = 1; dwe = 0; daddr = 8'h20; dwd = 0;
    acks = 0;
    for (int c = 0; c < 60 && acks < 6; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (cack && dack) begin
        n_bad++;
        $display("FAIL starve_dual_ack cyc%0d got=11 exp=not both", c);
      end
      if (cack || dack) begin
        n_cmp++;
        if (dack !== seq_exp[acks] ||
            (dack ? drd : crd) !== (dack ? 16'h1234 : 16'hBEEF)) begin
          n_bad++;
          $display("FAIL starve_ack%0d got owner=%0d data=%h exp owner=%0d",
                   acks, dack, dack ? drd : crd, seq_exp[acks]);
        end
        acks++;
      end
    end
    n_cmp++;
    if (acks != 6) begin
      n_bad++;
      $display("FAIL starve_timeout got=%0d acks exp=6", acks);
    end
    creq = 0; dreq = 0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL final_idle got busy=%b exp=0", busy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
